axi_burst_ram_slave: RTL

//  AXI responder (slave) memory model answering the caches' burst master ports (araddr/arlen/arsize,

---
 rtl/axi_burst_ram_slave_pkg.sv | 36 +++
 rtl/axi_burst_ram_slave_if.sv | 54 +++++
 rtl/axi_burst_ram_slave_addr_gen.sv | 51 +++++
 rtl/axi_burst_ram_slave.sv | 133 +++++++++++++
 4 files changed

// File: rtl/axi_burst_ram_slave_pkg.sv
// Package axi_slave_pkg: shared constants, FSM state encodings and size helpers
// for the AXI burst RAM responder.
//   LEN_W        width of arlen/awlen (beats minus 1)
//   SIZE_B/H/W   arsize/awsize codes for 1/2/4-byte beats
//   rd_state_t   read channel states, wr_state_t write channel states
//   clamp_size   maps illegal sizes (>2) onto word size
//   beat_step    byte increment between consecutive beats
package axi_slave_pkg;

  localparam int unsigned LEN_W = 4;

  localparam logic [2:0] SIZE_B = 3'd0;
  localparam logic [2:0] SIZE_H = 3'd1;
  localparam logic [2:0] SIZE_W = 3'd2;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  function automatic logic [2:0] clamp_size(input logic [2:0] size);
    return (size > SIZE_W) ? SIZE_W : size;
  endfunction

  function automatic logic [31:0] beat_step(input logic [2:0] size);
    return 32'd1 << clamp_size(size);
  endfunction

endpackage

// File: rtl/axi_burst_ram_slave_if.sv
// Interface axi_burst_ram_slave_if: AXI read/write burst channels between a
// cache burst master and the RAM responder.
//   AR: araddr, arlen, arsize, arvalid / arready
//   R : rdata, rlast, rvalid / rready
//   AW: awaddr, awlen, awsize, awvalid / awready
//   W : wdata, wstrb, wlast, wvalid / wready
//   B : bvalid / bready
// Modports: master (cache side), slave (memory side).
interface axi_burst_ram_slave_if;
  import axi_slave_pkg::*;

  logic [31:0]      araddr;
  logic [LEN_W-1:0] arlen;
  logic [2:0]       arsize;
  logic             arvalid;
  logic             arready;

  logic [31:0]      rdata;
  logic             rlast;
  logic             rvalid;
  logic             rready;

  logic [31:0]      awaddr;
  logic [LEN_W-1:0] awlen;
  logic [2:0]       awsize;
  logic             awvalid;
  logic             awready;

  logic [31:0]      wdata;
  logic [3:0]       wstrb;
  logic             wlast;
  logic             wvalid;
  logic             wready;

  logic             bvalid;
  logic             bready;

  modport master (
    output araddr, arlen, arsize, arvalid, rready,
    output awaddr, awlen, awsize, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    input  arready, rdata, rlast, rvalid,
    input  awready, wready, bvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arvalid, rready,
    input  awaddr, awlen, awsize, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    output arready, rdata, rlast, rvalid,
    output awready, wready, bvalid
  );

endinterface

// File: rtl/axi_burst_ram_slave_addr_gen.sv
// Module axi_beat_addr_gen: INCR burst beat address generator.
//   clk, rst     clock, asynchronous active-high reset
//   load         capture start_addr/start_len/start_size, beat count to 0
//   start_*      burst start byte address, beats minus 1, size code
//   step         advance to the next beat (addr += 1<<size, count++)
//   word_idx     RAM word index of the current beat (addr[IDX_W+1:2])
//   last         current beat is the final one of the burst
module axi_beat_addr_gen
  import axi_slave_pkg::*;
#(
  parameter int unsigned IDX_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [31:0]      start_addr,
  input  logic [LEN_W-1:0] start_len,
  input  logic [2:0]       start_size,
  input  logic             step,
  output logic [IDX_W-1:0] word_idx,
  output logic             last
);

  logic [31:0]      addr;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len;
  logic [2:0]       size;

  // Full 32-bit byte address is kept so narrow beats walk through a word's
  // byte lanes before moving on; only the word index leaves the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= '0;
      cnt  <= '0;
      len  <= '0;
      size <= '0;
    end else if (load) begin
      addr <= start_addr;
      cnt  <= '0;
      len  <= start_len;
      size <= clamp_size(start_size);
    end else if (step) begin
      addr <= addr + beat_step(size);
      cnt  <= cnt + 1'b1;
    end
  end

  assign word_idx = addr[IDX_W+1:2];
  assign last     = (cnt == len);

endmodule

// File: rtl/axi_burst_ram_slave.sv
// Module axi_burst_ram_slave: word-organised RAM answering AXI INCR bursts of
// 1..16 beats. Read and write channels run independently and concurrently.
//   clk   clock, all state changes on posedge
//   rst   asynchronous active-high reset (RAM contents are not cleared)
//   axi   slave side of the AR/R/AW/W/B channels
// Parameters:
//   DEPTH_LOG2  log2 of RAM depth in 32-bit words
//   READ_LAT    cycles from AR handshake to first rvalid (0 = next cycle)
module axi_burst_ram_slave
  import axi_slave_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned READ_LAT   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  axi_burst_ram_slave_if.slave   axi
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned LAT_W = (READ_LAT < 2) ? 1 : $clog2(READ_LAT + 1);

  logic [31:0] mem [DEPTH];

  rd_state_t             rd_state;
  wr_state_t             wr_state;
  logic [LAT_W-1:0]      lat_cnt;

  logic                  ar_hs;
  logic                  r_hs;
  logic                  aw_hs;
  logic                  w_hs;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic                  rd_last;
  logic                  wr_last;

  assign ar_hs = (rd_state == R_IDLE) && axi.arvalid;
  assign r_hs  = (rd_state == R_DATA) && axi.rready;
  assign aw_hs = (wr_state == W_IDLE) && axi.awvalid;
  assign w_hs  = (wr_state == W_DATA) && axi.wvalid;

  axi_beat_addr_gen #(
    .IDX_W (DEPTH_LOG2)
  ) u_rd_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (ar_hs),
    .start_addr (axi.araddr),
    .start_len  (axi.arlen),
    .start_size (axi.arsize),
    .step       (r_hs),
    .word_idx   (rd_idx),
    .last       (rd_last)
  );

  axi_beat_addr_gen #(
    .IDX_W (DEPTH_LOG2)
  ) u_wr_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (aw_hs),
    .start_addr (axi.awaddr),
    .start_len  (axi.awlen),
    .start_size (axi.awsize),
    .step       (w_hs),
    .word_idx   (wr_idx),
    .last       (wr_last)
  );

  // Read channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state <= R_IDLE;
      lat_cnt  <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (ar_hs) begin
            lat_cnt  <= LAT_W'(READ_LAT);
            rd_state <= (READ_LAT == 0) ? R_DATA : R_WAIT;
          end
        end
        R_WAIT: begin
          lat_cnt <= lat_cnt - 1'b1;
          if (lat_cnt == LAT_W'(1)) rd_state <= R_DATA;
        end
        R_DATA: begin
          if (r_hs && rd_last) rd_state <= R_IDLE;
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // Asynchronous RAM read: a write to the same word lands at the posedge
  // ending the cycle, so a coinciding read beat still sees the old word.
  // The beat address only moves on acceptance, so data holds while stalled.
  assign axi.arready = (rd_state == R_IDLE);
  assign axi.rvalid  = (rd_state == R_DATA);
  assign axi.rlast   = (rd_state == R_DATA) && rd_last;
  assign axi.rdata   = (rd_state == R_DATA) ? mem[rd_idx] : '0;

  // Write channel: the beat count alone ends the burst; wlast is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state <= W_IDLE;
    end else begin
      case (wr_state)
        W_IDLE: if (aw_hs) wr_state <= W_DATA;
        W_DATA: if (w_hs && wr_last) wr_state <= W_RESP;
        W_RESP: if (axi.bready) wr_state <= W_IDLE;
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  assign axi.awready = (wr_state == W_IDLE);
  assign axi.wready  = (wr_state == W_DATA);
  assign axi.bvalid  = (wr_state == W_RESP);

  always_ff @(posedge clk) begin
    if (w_hs) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (axi.wstrb[b]) mem[wr_idx][8*b +: 8] <= axi.wdata[8*b +: 8];
      end
    end
  end

  logic unused_wlast;
  assign unused_wlast = axi.wlast;

endmodule
